// File: rtl/conv_pkg.sv
// conv_pkg: FSM state encoding and default parameters for conv_stream_mac.
package conv_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_e;
  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_IN_CHANNELS = 1;
  localparam int DEF_ACC_WIDTH   = 40;
  localparam int DEF_OUT_WIDTH   = 16;
  localparam int DEF_FRAC_BITS   = 0;
endpackage

// File: rtl/conv_round_sat.sv
// conv_round_sat: round-half-up shift of the accumulator, then signed saturation to OUT_WIDTH.
module conv_round_sat #(
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [OUT_WIDTH-1:0] data,
  output logic                        sat
);
  localparam int A  = ACC_WIDTH;
  localparam int RS = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;
  localparam logic signed [A:0] RND  = (A+1)'(FRAC_BITS > 0) << RS;
  localparam logic signed [A:0] MAXV = {{(A+2-OUT_WIDTH){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [A:0] MINV = ~MAXV;
  // One guard bit keeps the rounding add from wrapping near the accumulator limit
  logic signed [A:0] sum, sh;
  always_comb begin
    sum  = {acc[A-1], acc} + RND;
    sh   = sum >>> FRAC_BITS;
    sat  = (sh > MAXV) || (sh < MINV);
    data = (sh > MAXV) ? MAXV[OUT_WIDTH-1:0] : (sh < MINV) ? MINV[OUT_WIDTH-1:0] : sh[OUT_WIDTH-1:0];
  end
endmodule

// File: rtl/conv_stream_mac.sv
// conv_stream_mac: streaming KxK multi-channel convolution MAC fed one column per beat,
// with kernel load, column-window FSM and a two-stage accumulate / round-saturate pipeline.
module conv_stream_mac
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IN_CHANNELS = DEF_IN_CHANNELS,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
  parameter int FRAC_BITS   = DEF_FRAC_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_valid,
  output logic                              s_ready,
  input  logic [KERNEL_SIZE*DATA_WIDTH-1:0] s_data,
  input  logic                              kernel_load,
  input  logic                              s_last,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [OUT_WIDTH-1:0]              m_data,
  output logic                              sat,
  output logic                              protocol_err
);
  localparam int K   = KERNEL_SIZE;
  localparam int C   = IN_CHANNELS;
  localparam int CW  = K * DATA_WIDTH;
  localparam int KW  = $clog2(K + 1);
  localparam int CHW = (C > 1) ? $clog2(C) : 1;
  state_e st_q, st_d;
  logic [CW-1:0] kern_q [C][K], kern_d [C][K], win_q [C][K], win_d [C][K];
  logic [CHW-1:0] kc_q, kc_d, ch_q, ch_d, kc;
  logic [KW-1:0] kj_q, kj_d, col_q, col_d, kj;
  logic rdy_q, l_q, l_d, v1_q, mv_q, perr_q, perr_d, sat_q, rs_sat;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [OUT_WIDTH-1:0] md_q, rs_data;
  logic stall, empty, streaming, kbeat, dbeat, col_done;
  always_comb begin
    streaming = (st_q == FILL) || (st_q == RUN);
    stall     = mv_q & ~m_ready;
    empty     = ~(l_q | v1_q | mv_q);
    s_ready   = rdy_q & ~stall & ~(kernel_load & streaming & ~empty);
    kbeat     = s_valid & s_ready & kernel_load;
    dbeat     = s_valid & s_ready & ~kernel_load;
    col_done  = dbeat & streaming & (ch_q == CHW'(C - 1));
    kc        = (st_q == LOAD) ? kc_q : '0;
    kj        = (st_q == LOAD) ? kj_q : '0;
  end
  always_comb begin
    st_d   = st_q;
    kern_d = kern_q;
    win_d  = win_q;
    kc_d   = kc_q;
    kj_d   = kj_q;
    ch_d   = ch_q;
    col_d  = col_q;
    l_d    = 1'b0;
    perr_d = dbeat & ~streaming;
    if (kbeat) begin
      st_d         = LOAD;
      kern_d[kc][kj] = s_data;
      kj_d         = (kj == KW'(K - 1)) ? '0 : kj + KW'(1);
      kc_d         = (kj == KW'(K - 1)) ? kc + CHW'(1) : kc;
      if (kj == KW'(K - 1) && kc == CHW'(C - 1)) begin
        st_d  = FILL;
        kc_d  = '0;
        col_d = '0;
        ch_d  = '0;
      end
    end else if (dbeat && streaming) begin
      for (int j = 0; j < K - 1; j++) win_d[ch_q][j] = win_q[ch_q][j+1];
      win_d[ch_q][K-1] = s_data;
      ch_d = col_done ? '0 : ch_q + CHW'(1);
      if (col_done) begin
        l_d   = (st_q == RUN) || (col_q == KW'(K - 1));
        col_d = (st_q == FILL) ? col_q + KW'(1) : col_q;
        st_d  = l_d ? RUN : FILL;
        // Row end: the launch above still happens, the next row refills from scratch
        if (s_last) begin
          st_d  = FILL;
          col_d = '0;
        end
      end
    end
  end
  always_comb begin
    acc_d = '0;
    for (int c = 0; c < C; c++)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          acc_d = acc_d + ACC_WIDTH'($signed(kern_q[c][i][j*DATA_WIDTH +: DATA_WIDTH]) *
                                     $signed(win_q[c][i][j*DATA_WIDTH +: DATA_WIDTH]));
  end
  conv_round_sat #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH), .FRAC_BITS(FRAC_BITS)) u_rs (
    .acc(acc_q), .data(rs_data), .sat(rs_sat)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= IDLE;
      kern_q <= '{default: '0};
      win_q  <= '{default: '0};
      kc_q   <= '0;
      kj_q   <= '0;
      ch_q   <= '0;
      col_q  <= '0;
      rdy_q  <= 1'b0;
      perr_q <= 1'b0;
      l_q    <= 1'b0;
      v1_q   <= 1'b0;
      acc_q  <= '0;
      mv_q   <= 1'b0;
      md_q   <= '0;
      sat_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      kern_q <= kern_d;
      win_q  <= win_d;
      kc_q   <= kc_d;
      kj_q   <= kj_d;
      ch_q   <= ch_d;
      col_q  <= col_d;
      rdy_q  <= 1'b1;
      perr_q <= perr_d;
      if (!stall) begin
        l_q   <= l_d;
        v1_q  <= l_q;
        acc_q <= acc_d;
        mv_q  <= v1_q;
        md_q  <= rs_data;
        sat_q <= rs_sat & v1_q;
      end
    end
  end
  assign m_valid      = mv_q;
  assign m_data       = md_q;
  assign sat          = sat_q;
  assign protocol_err = perr_q;
endmodule

// File: tb/tb_conv_stream_mac.sv
// tb_conv_stream_mac: scoreboard bench over three instances (C=1, C=2, FRAC_BITS=1) of conv_stream_mac.
module tb_conv_stream_mac;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rn [3], sv [3], kl [3], sl [3], mr [3], sr [3], mv [3], st [3], pe [3];
  logic [47:0] sd [3];
  logic [15:0] md [3];
  logic [16:0] q [3][$];
  logic stl [3];
  logic [16:0] held [3];
  int checks = 0, fails = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    conv_stream_mac #(.IN_CHANNELS(g == 1 ? 2 : 1), .FRAC_BITS(g == 2 ? 1 : 0)) u (
      .clk(clk), .rst_n(rn[g]), .s_valid(sv[g]), .s_ready(sr[g]), .s_data(sd[g]),
      .kernel_load(kl[g]), .s_last(sl[g]), .m_valid(mv[g]), .m_ready(mr[g]),
      .m_data(md[g]), .sat(st[g]), .protocol_err(pe[g])
    );
  end
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: pops on every handshake, and watches held outputs while stalled
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (mv[i] && mr[i]) begin
        if (q[i].size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_out dut%0d: got %0h expected none", i, {md[i], st[i]});
        end else chk($sformatf("out_dut%0d", i), {md[i], st[i]}, q[i].pop_front());
      end
      if (mv[i] && !mr[i]) begin
        chk($sformatf("stall_sready_dut%0d", i), sr[i], 0);
        if (stl[i]) chk($sformatf("stall_hold_dut%0d", i), {md[i], st[i]}, held[i]);
      end
      stl[i]  = mv[i] && !mr[i];
      held[i] = {md[i], st[i]};
    end
  end
  function automatic logic [47:0] col(int a, int b, int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction
  task automatic put(int i, logic k, logic [47:0] d, logic l);
    int n;
    sv[i] = 1'b1; kl[i] = k; sd[i] = d; sl[i] = l;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sr[i] && n < 300);
    if (!sr[i]) begin
      checks++;
      fails++;
      $display("FAIL put_timeout dut%0d: got s_ready=0 expected 1", i);
    end
    @(posedge clk);
    #1 sv[i] = 1'b0; kl[i] = 1'b0; sl[i] = 1'b0;
  endtask
  task automatic kload(int i, logic [47:0] w, int nb);
    repeat (nb) put(i, 1'b1, w, 1'b0);
  endtask
  task automatic drain(int i);
    int n;
    n = 0;
    while (q[i].size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk($sformatf("drain_dut%0d", i), q[i].size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      rn[i] = 0; sv[i] = 0; kl[i] = 0; sl[i] = 0; sd[i] = '0; mr[i] = 1; stl[i] = 0; held[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", mv[0], 0);
    chk("rst_s_ready", sr[0], 0);
    chk("rst_perr", pe[0], 0);
    chk("rst_m_data", md[0], 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) rn[i] = 1;
    #1 chk("sready_before_edge", sr[0], 0);
    @(posedge clk);
    #1 chk("sready_after_edge", sr[0], 1);
    // All-ones kernel, three columns of 2 -> 18 two cycles after the third column
    kload(0, col(1, 1, 1), 3);
    put(0, 0, col(2, 2, 2), 0);
    put(0, 0, col(2, 2, 2), 0);
    q[0].push_back({16'd18, 1'b0});
    put(0, 0, col(2, 2, 2), 0);
    chk("lat_e0", mv[0], 0);
    @(posedge clk);
    #1 chk("lat_e1", mv[0], 0);
    @(posedge clk);
    #1 chk("lat_e2", mv[0], 1);
    // Saturation both ways
    kload(0, col(32767, 32767, 32767), 3);
    repeat (2) put(0, 0, col(32767, 32767, 32767), 0);
    q[0].push_back({16'h7fff, 1'b1});
    put(0, 0, col(32767, 32767, 32767), 0);
    kload(0, col(-1, -1, -1), 3);
    repeat (2) put(0, 0, col(32767, 32767, 32767), 0);
    q[0].push_back({16'h8000, 1'b1});
    put(0, 0, col(32767, 32767, 32767), 0);
    drain(0);
    // Two channels: 9*5 - 9*3 = 18
    kload(1, col(1, 1, 1), 3);
    kload(1, col(-1, -1, -1), 3);
    for (int c = 0; c < 3; c++) begin
      put(1, 0, col(5, 5, 5), 0);
      if (c == 2) q[1].push_back({16'd18, 1'b0});
      put(1, 0, col(3, 3, 3), 0);
    end
    drain(1);
    // FRAC_BITS=1 rounding: 3 -> 2, -3 -> -1
    kload(2, col(1, 1, 1), 3);
    put(2, 0, col(3, 0, 0), 0);
    put(2, 0, col(0, 0, 0), 0);
    q[2].push_back({16'd2, 1'b0});
    put(2, 0, col(0, 0, 0), 1);
    put(2, 0, col(-3, 0, 0), 0);
    put(2, 0, col(0, 0, 0), 0);
    q[2].push_back({16'hffff, 1'b0});
    put(2, 0, col(0, 0, 0), 0);
    drain(2);
    // Backpressure: columns v,v,v give 9v-9 once the window holds v-2..v
    kload(0, col(1, 1, 1), 3);
    fork
      for (int v = 1; v <= 8; v++) begin
        if (v >= 3) q[0].push_back({16'(9 * v - 9), 1'b0});
        put(0, 0, col(v, v, v), 0);
      end
      begin
        repeat (6) @(posedge clk);
        #1 mr[0] = 0;
        repeat (5) @(posedge clk);
        #1 mr[0] = 1;
      end
    join
    drain(0);
    // Row end on column 4: outputs at 3 and 4, none at 5 and 6, one at 7
    kload(0, col(1, 1, 1), 3);
    for (int v = 1; v <= 7; v++) begin
      if (v == 3) q[0].push_back({16'd18, 1'b0});
      if (v == 4) q[0].push_back({16'd27, 1'b0});
      if (v == 7) q[0].push_back({16'd54, 1'b0});
      put(0, 0, col(v, v, v), v == 4);
    end
    drain(0);
    // Reset while a result is held: it must vanish and the kernel must be reloaded
    kload(0, col(1, 1, 1), 3);
    mr[0] = 0;
    repeat (3) put(0, 0, col(2, 2, 2), 0);
    begin
      int n;
      n = 0;
      while (!mv[0] && n < 50) begin
        @(posedge clk);
        n++;
      end
    end
    chk("rst_wait_valid", mv[0], 1);
    #2 rn[0] = 0;
    #1 chk("midrst_m_valid", mv[0], 0);
    chk("midrst_s_ready", sr[0], 0);
    @(negedge clk);
    rn[0] = 1;
    mr[0] = 1;
    @(posedge clk);
    #1;
    put(0, 0, col(2, 2, 2), 0);
    chk("perr_pulse", pe[0], 1);
    @(posedge clk);
    #1 chk("perr_clear", pe[0], 0);
    put(0, 0, col(2, 2, 2), 0);
    chk("perr_again", pe[0], 1);
    kload(0, col(1, 1, 1), 3);
    repeat (2) put(0, 0, col(2, 2, 2), 0);
    q[0].push_back({16'd18, 1'b0});
    put(0, 0, col(2, 2, 2), 0);
    chk("perr_after_load", pe[0], 0);
    for (int i = 0; i < 3; i++) drain(i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
